// File: rtl/output_deskew_pkg.sv
// Shared configuration for the accumulator output path: array geometry,
// row FIFO depth, drain FSM states and the optional ReLU clamp helper.
package Config;
  localparam int sys_cols       = 4;
  localparam int P_BITWIDTH     = 16;
  localparam int OUT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} drain_state_t;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t;

  // Clamp every signed element of a row to zero if it is negative.
  function automatic row_t relu_row(input row_t r);
    row_t o;
    for (int j = 0; j < sys_cols; j++)
      o[j] = r[j][P_BITWIDTH-1] ? '0 : r[j];
    return o;
  endfunction
endpackage

// File: rtl/output_deskew_row_fifo.sv
// Row FIFO for aligned output rows. A push while full only lands if a pop
// frees a slot in the same cycle; reads come from registered storage only.
module row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/output_deskew.sv
// Deskews the column-staggered accumulator stream into whole rows, buffers
// them for write-back and reports drain completion. OUT_RELU_EN clamps negatives.
module output_deskew
  import Config::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [sys_cols-1:0]                  read_out,
  input  logic [sys_cols-1:0][P_BITWIDTH-1:0]  i_data,
  input  logic                                 acc_done,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [sys_cols-1:0][P_BITWIDTH-1:0]  o_data,
  output logic [15:0]                          o_row_cnt,
  output logic                                 o_done,
  output logic                                 overflow,
  output logic                                 align_err
);
  localparam int RW = sys_cols*P_BITWIDTH;

  logic [sys_cols-1:0] al_vld, col_busy;
  row_t                al_data, wr_row;
  logic                push, row_pop, fifo_full, fifo_empty;
  logic [$clog2(OUT_FIFO_DEPTH):0] fifo_count;
  drain_state_t        state;

  // Column j: one capture register plus sys_cols-1-j deskew registers.
  for (genvar j = 0; j < sys_cols; j++) begin : g_col
    localparam int D = sys_cols-1-j;
    logic [D:0]                 vld_pipe;
    logic [D:0][P_BITWIDTH-1:0] dat_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[0] <= read_out[j];
        dat_pipe[0] <= i_data[j];
        for (int k = 1; k <= D; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end

    assign al_vld[j]   = vld_pipe[D];
    assign al_data[j]  = dat_pipe[D];
    assign col_busy[j] = |vld_pipe;
  end

  assign push    = al_vld[0];
  assign row_pop = o_valid && o_ready;
  assign o_valid = !fifo_empty;
  assign o_done  = (state == DONE);

`ifdef OUT_RELU_EN
  assign wr_row = relu_row(al_data);
`else
  assign wr_row = al_data;
`endif

  row_fifo #(.WIDTH(RW), .DEPTH(OUT_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_row),
    .pop   (row_pop),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (push && fifo_full && !row_pop) overflow <= 1'b1;
      if (al_vld != {sys_cols{al_vld[0]}}) align_err <= 1'b1;
    end
  end

  // Row counter restarts only when a new burst begins from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_row_cnt <= '0;
    end else begin
      if (row_pop) o_row_cnt <= o_row_cnt + 16'd1;
      case (state)
        IDLE:
          if (acc_done) state <= DRAIN;
          else if (read_out[0]) begin
            state     <= ACTIVE;
            o_row_cnt <= '0;
          end
        ACTIVE: if (acc_done) state <= DRAIN;
        DRAIN:  if (!(|col_busy) && fifo_count == '0) state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/output_deskew.md
# output_deskew

Downstream stage of the accumulator. It takes the column-skewed `o_data`/`read_out` stream and delays each column so that every finished output row is aligned into one word. Aligned rows are buffered in a small row FIFO and presented on a valid/ready interface for write-back. It also reports drain completion once the accumulator has signalled `done` and every in-flight row has left the block.

## Interface
- `sys_cols`, from `Config`: number of systolic columns (column j trails column j-1 by one cycle).
- `P_BITWIDTH`, from `Config`: bit width of each partial-sum / result element.
- `OUT_FIFO_DEPTH`, 4: row FIFO depth in rows; a power of two, ≥2.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `read_out`  in  `[sys_cols-1:0]`  per-column result strobe; bit j is bit 0 delayed by j cycles.
- `i_data`  in  `[sys_cols-1:0][P_BITWIDTH-1:0]`  accumulator `o_data`; element j is valid in the cycle `read_out[j]` is high.
- `acc_done`  in  1  one-cycle pulse from the accumulator `done`.
- `o_valid`  out  1  an aligned row is available.
- `o_ready`  in  1  consumer accepts the row.
- `o_data`  out  `[sys_cols-1:0][P_BITWIDTH-1:0]`  aligned row; element j belongs to column j.
- `o_row_cnt`  out  16  rows popped since the last IDLE→ACTIVE transition.
- `o_done`  out  1  one-cycle pulse when the drain is complete.
- `overflow`  out  1  sticky flag: a row was dropped.
- `align_err`  out  1  sticky flag: deskewed valid bits disagreed.

## Operation
- **Capture.** All columns register `read_out`/`i_data` once (stage 0).
- **Deskew.** Column j then passes through `sys_cols-1-j` further registers. Column `sys_cols-1` gets none. Data and strobe are delayed together.
- **Row valid.** The aligned row is valid when deskewed strobe bit 0 is high. If any aligned strobe bit differs from bit 0, set `align_err`; the row is still pushed if bit 0 is high.
- **Push.** An aligned-valid row is written into the row FIFO.
- **Full FIFO.** A push while full with no pop in the same cycle drops the row and sets `overflow`. A push while full with a pop in the same cycle succeeds.
- **Pop.** A row pops on `o_valid && o_ready`, and `o_row_cnt` increments. The counter wraps at 2^16.
- **FSM (`drain_state_t`).**
  - IDLE→ACTIVE on `read_out[0]`; `o_row_cnt` clears on this transition.
  - ACTIVE→DRAIN on `acc_done`.
  - DRAIN→DONE when all deskew strobes are 0 and the FIFO is empty.
  - DONE→IDLE unconditionally after one cycle.
  - `o_done` = (state == DONE).
- **`acc_done` in IDLE.** Goes straight to DRAIN, producing `o_done` two cycles later if the block is empty.
- **`read_out[0]` in DRAIN/DONE.** Accepted and pushed normally; it does not change state.
- **Reset.** Clears all deskew registers, the FIFO pointers and count, and the state to IDLE. Outputs after reset: `o_valid`=0, `o_data`=0, `o_row_cnt`=0, `o_done`=0, `overflow`=0, `align_err`=0. Reset mid-operation discards all in-flight rows without asserting `o_done`.

## Timing
- Row whose `read_out[0]` is high in cycle t:
  - aligned at stage output in cycle t+`sys_cols`;
  - written at the edge ending that cycle;
  - `o_valid` high from cycle t+`sys_cols`+1.
- Back-to-back rows: one row per cycle sustained while `o_ready`=1.
- `o_data` is stable while `o_valid && !o_ready`.
- `o_valid` is driven from FIFO not-empty (registered state). There is no combinational path from `o_ready` to `o_valid`.
- `overflow` and `align_err` assert the cycle after the offending event.

## Configuration
- `OUT_RELU_EN` defined: each element is treated as signed and clamped to 0 if negative at FIFO write.
- `OUT_RELU_EN` undefined: elements are stored unchanged. Latency is identical in both builds.

## Structure
- Add to package `Config`: `OUT_FIFO_DEPTH` and `typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} drain_state_t`.
- Sub-module `row_fifo`:
  - parameters: width = `sys_cols*P_BITWIDTH`, depth = `OUT_FIFO_DEPTH`;
  - ports: push, pop, full, empty, count;
  - no fall-through from push.
- The deskew chain lives in a generate loop in the top module.

## Test plan
- `sys_cols`=4, one row of values 1,2,3,4 on staggered strobes, `o_ready`=1 → `o_valid` one cycle at t+5 with row {1,2,3,4}; `o_row_cnt`=1.
- 8 consecutive rows, `o_ready`=0 until row 8 aligns, depth 4 → rows 1–4 retained in order, `overflow`=1, 4 pops after `o_ready`=1.
- Push and pop in the same cycle while full → no drop, `overflow` stays 0.
- `acc_done` one cycle after the last `read_out[0]` → `o_done` pulses exactly once, after the last row pops.
- Corrupt strobe (`read_out[2]` missing for one row) → `align_err`=1 and the row is still delivered.
- Element −5 with `OUT_RELU_EN` → output 0; without the macro → −5. `rst` asserted mid-row → all outputs 0 next cycle and no `o_done`.
